// File: rtl/replay_pkg.sv
// Shared types and MISR helpers for the on-chip vector replay checker.
package replay_pkg;

  typedef enum logic [1:0] {IDLE, ACCEPT, SETTLE, DONE} state_t;

  localparam logic [15:0] MISR_POLY = 16'h1021;
  localparam logic [15:0] MISR_SEED = 16'hFFFF;

  // One MISR step: shift left, fold the feedback polynomial, absorb the response.
  function automatic logic [15:0] misr_next(input logic [15:0] sig, input logic [15:0] data);
    return {sig[14:0], 1'b0} ^ (sig[15] ? MISR_POLY : 16'h0000) ^ data;
  endfunction

endpackage

// File: rtl/replay_misr.sv
// 16-bit MISR compacting every sampled DUT response into a signature.
module replay_misr
  import replay_pkg::*;
(
  input  logic        CK,
  input  logic        reset,
  input  logic        clear,
  input  logic        enable,
  input  logic [15:0] data,
  output logic [15:0] signature
);

  // Clear wins over enable so a new run always starts from the seed.
  always_ff @(posedge CK or posedge reset) begin
    if (reset) begin
      signature <= MISR_SEED;
    end else if (clear) begin
      signature <= MISR_SEED;
    end else if (enable) begin
      signature <= misr_next(signature, data);
    end
  end

endmodule

// File: rtl/vector_replay_checker.sv
// Replays stored stimulus/expected vectors into a DUT, compares settled
// responses and accumulates mismatch statistics plus a MISR signature.
module vector_replay_checker #(
  parameter int IN_W   = 1,
  parameter int OUT_W  = 1,
  parameter int SETTLE = 1,
  parameter int CNT_W  = 16
) (
  input  logic             CK,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic             vec_valid,
  output logic             vec_ready,
  input  logic [IN_W-1:0]  vec_stim,
  input  logic [OUT_W-1:0] vec_exp,
  input  logic             vec_last,
  output logic [IN_W-1:0]  dut_in,
  input  logic [OUT_W-1:0] dut_out,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] vec_cnt,
  output logic [CNT_W-1:0] mismatch_cnt,
  output logic [CNT_W-1:0] first_fail_idx,
  output logic [15:0]      signature
);

  import replay_pkg::*;

  localparam int SC_W = $clog2(SETTLE + 1);

  state_t           state;
  state_t           state_next;
  logic [SC_W-1:0]  settle_cnt;
  logic [OUT_W-1:0] exp_q;
  logic             last_q;
  logic             accept;
  logic             sample;
  logic             clear_run;
  logic             resp_bad;
  logic [15:0]      resp_ext;

  always_ff @(posedge CK or posedge reset) begin
    if (reset) begin
      state <= replay_pkg::IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Abort overrides every other transition, including a same-cycle accept or sample.
  always_comb begin
    state_next = state;
    vec_ready  = (state == replay_pkg::ACCEPT);
    accept     = vec_valid && (state == replay_pkg::ACCEPT);
    sample     = (state == replay_pkg::SETTLE) && (settle_cnt == SC_W'(1));
    clear_run  = start && !abort &&
                 ((state == replay_pkg::IDLE) || (state == replay_pkg::DONE));
    resp_bad   = (dut_out != exp_q);
    resp_ext   = '0;
    resp_ext[OUT_W-1:0] = dut_out;
    if (abort) begin
      state_next = replay_pkg::IDLE;
    end else begin
      case (state)
        replay_pkg::IDLE:   if (start) state_next = replay_pkg::ACCEPT;
        replay_pkg::ACCEPT: if (accept) state_next = replay_pkg::SETTLE;
        replay_pkg::SETTLE: if (sample) state_next = last_q ? replay_pkg::DONE : replay_pkg::ACCEPT;
        replay_pkg::DONE:   if (start) state_next = replay_pkg::ACCEPT;
        default:            state_next = replay_pkg::IDLE;
      endcase
    end
  end

  assign busy = (state == replay_pkg::ACCEPT) || (state == replay_pkg::SETTLE);
  assign done = (state == replay_pkg::DONE);
  assign pass = done && (mismatch_cnt == '0);

  // Counters are kept across abort so a stopped run can still be inspected.
  always_ff @(posedge CK or posedge reset) begin
    if (reset) begin
      dut_in         <= '0;
      exp_q          <= '0;
      last_q         <= 1'b0;
      settle_cnt     <= '0;
      vec_cnt        <= '0;
      mismatch_cnt   <= '0;
      first_fail_idx <= '1;
    end else if (abort) begin
      dut_in <= '0;
    end else begin
      if (clear_run) begin
        vec_cnt        <= '0;
        mismatch_cnt   <= '0;
        first_fail_idx <= '1;
      end
      if (accept) begin
        dut_in     <= vec_stim;
        exp_q      <= vec_exp;
        last_q     <= vec_last;
        settle_cnt <= SC_W'(SETTLE);
      end else if (state == replay_pkg::SETTLE) begin
        settle_cnt <= settle_cnt - SC_W'(1);
      end
      if (sample) begin
        if (resp_bad) begin
          if (mismatch_cnt != '1) mismatch_cnt <= mismatch_cnt + CNT_W'(1);
          if (mismatch_cnt == '0) first_fail_idx <= vec_cnt;
        end
        if (vec_cnt != '1) vec_cnt <= vec_cnt + CNT_W'(1);
      end
    end
  end

  replay_misr u_misr (
    .CK        (CK),
    .reset     (reset),
    .clear     (clear_run),
    .enable    (sample && !abort),
    .data      (resp_ext),
    .signature (signature)
  );

endmodule

// File: tb/tb_vector_replay_checker.sv
// Scoreboard bench: three checker instances (buffer/inverter, 2-bit counters,
// slow DUT with SETTLE=3) share one stimulus bus selected by sel.
module tb_vector_replay_checker;

  typedef struct {
    logic [15:0] vc;
    logic [15:0] mc;
    logic [15:0] ff;
    logic        ps;
    logic [15:0] sig;
  } res_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       vec_valid = 1'b0;
  logic [3:0] vec_stim = '0;
  logic [3:0] vec_exp = '0;
  logic       vec_last = 1'b0;
  logic       invert_a = 1'b0;
  int         sel = 0;
  int         cyc = 0;
  int         n_cmp = 0;
  int         n_fail = 0;
  int         acc_cyc = 0;
  res_t       sb[$];

  logic        ready_a, busy_a, done_a, pass_a;
  logic [0:0]  dut_in_a, dut_out_a;
  logic [15:0] vc_a, mc_a, ff_a, sig_a;
  logic        ready_b, busy_b, done_b, pass_b;
  logic [0:0]  dut_in_b, dut_out_b;
  logic [1:0]  vc_b, mc_b, ff_b;
  logic [15:0] sig_b;
  logic        ready_c, busy_c, done_c, pass_c;
  logic [3:0]  dut_in_c, dut_out_c, pipe_c;
  logic [15:0] vc_c, mc_c, ff_c, sig_c;

  logic ready_m, busy_m, done_m;
  res_t act;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  assign dut_out_a = dut_in_a ^ invert_a;
  assign dut_out_b = ~dut_in_b;

  // Two-cycle latency DUT for the SETTLE=3 instance.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      pipe_c    <= '0;
      dut_out_c <= '0;
    end else begin
      pipe_c    <= dut_in_c;
      dut_out_c <= pipe_c;
    end
  end

  vector_replay_checker #(.IN_W(1), .OUT_W(1), .SETTLE(1), .CNT_W(16)) dut_a (
    .CK(clk), .reset(reset), .start(start && sel == 0), .abort(abort),
    .vec_valid(vec_valid), .vec_ready(ready_a), .vec_stim(vec_stim[0:0]),
    .vec_exp(vec_exp[0:0]), .vec_last(vec_last), .dut_in(dut_in_a),
    .dut_out(dut_out_a), .busy(busy_a), .done(done_a), .pass(pass_a),
    .vec_cnt(vc_a), .mismatch_cnt(mc_a), .first_fail_idx(ff_a), .signature(sig_a));

  vector_replay_checker #(.IN_W(1), .OUT_W(1), .SETTLE(1), .CNT_W(2)) dut_b (
    .CK(clk), .reset(reset), .start(start && sel == 1), .abort(abort),
    .vec_valid(vec_valid), .vec_ready(ready_b), .vec_stim(vec_stim[0:0]),
    .vec_exp(vec_exp[0:0]), .vec_last(vec_last), .dut_in(dut_in_b),
    .dut_out(dut_out_b), .busy(busy_b), .done(done_b), .pass(pass_b),
    .vec_cnt(vc_b), .mismatch_cnt(mc_b), .first_fail_idx(ff_b), .signature(sig_b));

  vector_replay_checker #(.IN_W(4), .OUT_W(4), .SETTLE(3), .CNT_W(16)) dut_c (
    .CK(clk), .reset(reset), .start(start && sel == 2), .abort(abort),
    .vec_valid(vec_valid), .vec_ready(ready_c), .vec_stim(vec_stim),
    .vec_exp(vec_exp), .vec_last(vec_last), .dut_in(dut_in_c),
    .dut_out(dut_out_c), .busy(busy_c), .done(done_c), .pass(pass_c),
    .vec_cnt(vc_c), .mismatch_cnt(mc_c), .first_fail_idx(ff_c), .signature(sig_c));

  // Route the selected instance onto the shared observation signals.
  always_comb begin
    ready_m = ready_a; busy_m = busy_a; done_m = done_a;
    act.vc = vc_a; act.mc = mc_a; act.ff = ff_a; act.ps = pass_a; act.sig = sig_a;
    if (sel == 1) begin
      ready_m = ready_b; busy_m = busy_b; done_m = done_b;
      act.vc = {14'b0, vc_b}; act.mc = {14'b0, mc_b}; act.ff = {14'b0, ff_b};
      act.ps = pass_b; act.sig = sig_b;
    end else if (sel == 2) begin
      ready_m = ready_c; busy_m = busy_c; done_m = done_c;
      act.vc = vc_c; act.mc = mc_c; act.ff = ff_c; act.ps = pass_c; act.sig = sig_c;
    end
  end

  task automatic check_output(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic push_exp(input logic [15:0] vc, mc, ff, input logic ps, input logic [15:0] sig);
    res_t r;
    r.vc = vc; r.mc = mc; r.ff = ff; r.ps = ps; r.sig = sig;
    sb.push_back(r);
  endtask

  // Monitor: every completed run is popped from the scoreboard and compared.
  initial begin
    res_t e;
    forever begin
      @(posedge done_m);
      @(negedge clk);
      if (sb.size() == 0) begin
        n_cmp++; n_fail++;
        $display("[TB] FAIL unexpected_done: got done with empty scoreboard, required none");
      end else begin
        e = sb.pop_front();
        check_output("run_vec_cnt", 32'(act.vc), 32'(e.vc));
        check_output("run_mismatch_cnt", 32'(act.mc), 32'(e.mc));
        check_output("run_first_fail_idx", 32'(act.ff), 32'(e.ff));
        check_output("run_pass", 32'(act.ps), 32'(e.ps));
        check_output("run_signature", 32'(act.sig), 32'(e.sig));
      end
    end
  end

  task automatic start_run();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  // Present one vector and return at the negedge just after it was accepted.
  task automatic apply_stimulus(input logic [3:0] s, input logic [3:0] e, input logic l);
    int n;
    vec_valid = 1'b1; vec_stim = s; vec_exp = e; vec_last = l;
    n = 0;
    while (!ready_m && n < 100) begin @(negedge clk); n++; end
    if (!ready_m) begin
      n_cmp++; n_fail++;
      $display("[TB] FAIL accept_timeout: got vec_ready=0 after %0d cycles, required 1", n);
    end
    @(negedge clk);
    acc_cyc = cyc;
  endtask

  task automatic wait_done();
    int n;
    vec_valid = 1'b0;
    n = 0;
    while (!done_m && n < 200) begin @(negedge clk); n++; end
    if (!done_m) begin
      n_cmp++; n_fail++;
      $display("[TB] FAIL done_timeout: got done=0 after %0d cycles, required 1", n);
    end
    @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int first_acc;
    int prev_acc;
    repeat (3) @(negedge clk);
    check_output("rst_dut_in", 32'(dut_in_a), 0);
    check_output("rst_vec_ready", 32'(ready_a), 0);
    check_output("rst_busy", 32'(busy_a), 0);
    check_output("rst_done", 32'(done_a), 0);
    check_output("rst_pass", 32'(pass_a), 0);
    check_output("rst_vec_cnt", 32'(vc_a), 0);
    check_output("rst_first_fail", 32'(ff_a), 32'hFFFF);
    check_output("rst_signature", 32'(sig_a), 32'hFFFF);
    reset = 1'b0;

    // Buffer DUT: both vectors match; done arrives 3 edges after the first accept.
    push_exp(16'd2, 16'd0, 16'hFFFF, 1'b1, 16'hCF9E);
    start_run();
    check_output("busy_after_start", 32'(busy_a), 1);
    apply_stimulus(4'h0, 4'h0, 1'b0);
    first_acc = acc_cyc;
    apply_stimulus(4'h1, 4'h1, 1'b1);
    wait_done();
    check_output("latency_accept_to_done", 32'(cyc - 1 - first_acc), 3);

    // Inverter DUT: every vector fails.
    invert_a = 1'b1;
    push_exp(16'd2, 16'd2, 16'd0, 1'b0, 16'hCF9D);
    start_run();
    apply_stimulus(4'h0, 4'h0, 1'b0);
    apply_stimulus(4'h1, 4'h1, 1'b1);
    wait_done();
    invert_a = 1'b0;

    // Backpressure: valid low for three cycles keeps ready high without counting.
    push_exp(16'd2, 16'd0, 16'hFFFF, 1'b1, 16'hCF9E);
    start_run();
    apply_stimulus(4'h0, 4'h0, 1'b0);
    vec_valid = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check_output("bp_vec_ready", 32'(ready_a), 1);
    end
    check_output("bp_vec_cnt", 32'(vc_a), 1);
    apply_stimulus(4'h1, 4'h1, 1'b1);
    wait_done();

    // Asynchronous reset while a vector is settling.
    start_run();
    apply_stimulus(4'h1, 4'h1, 1'b0);
    vec_valid = 1'b0;
    #2 reset = 1'b1;
    #1;
    check_output("arst_dut_in", 32'(dut_in_a), 0);
    check_output("arst_busy", 32'(busy_a), 0);
    check_output("arst_vec_ready", 32'(ready_a), 0);
    check_output("arst_vec_cnt", 32'(vc_a), 0);
    check_output("arst_signature", 32'(sig_a), 32'hFFFF);
    @(negedge clk); reset = 1'b0;

    // Abort in ACCEPT keeps the debug state and clears dut_in.
    start_run();
    apply_stimulus(4'h0, 4'h1, 1'b0);
    vec_valid = 1'b0;
    @(negedge clk); abort = 1'b1;
    @(negedge clk); abort = 1'b0;
    check_output("abort_busy", 32'(busy_a), 0);
    check_output("abort_done", 32'(done_a), 0);
    check_output("abort_vec_cnt", 32'(vc_a), 1);
    check_output("abort_mismatch_cnt", 32'(mc_a), 1);
    check_output("abort_first_fail", 32'(ff_a), 0);
    check_output("abort_signature", 32'(sig_a), 32'hEFDF);
    check_output("abort_dut_in", 32'(dut_in_a), 0);
    push_exp(16'd2, 16'd0, 16'hFFFF, 1'b1, 16'hCF9E);
    start_run();
    check_output("restart_vec_cnt", 32'(vc_a), 0);
    check_output("restart_mismatch_cnt", 32'(mc_a), 0);
    check_output("restart_signature", 32'(sig_a), 32'hFFFF);
    apply_stimulus(4'h0, 4'h0, 1'b0);
    apply_stimulus(4'h1, 4'h1, 1'b1);
    wait_done();

    // Two-bit counters saturate at 3 over five failing vectors.
    sel = 1;
    push_exp(16'd3, 16'd3, 16'd0, 1'b0, 16'h1C21);
    start_run();
    for (int i = 0; i < 5; i++) apply_stimulus(4'h0, 4'h0, i == 4);
    wait_done();

    // SETTLE=3 against a two-cycle-latency DUT: all pass, 4 cycles per vector.
    sel = 2;
    push_exp(16'd3, 16'd0, 16'hFFFF, 1'b1, 16'h8F1C);
    start_run();
    apply_stimulus(4'h5, 4'h5, 1'b0);
    prev_acc = acc_cyc;
    apply_stimulus(4'hA, 4'hA, 1'b0);
    check_output("settle3_spacing_1", 32'(acc_cyc - prev_acc), 4);
    prev_acc = acc_cyc;
    apply_stimulus(4'h3, 4'h3, 1'b1);
    check_output("settle3_spacing_2", 32'(acc_cyc - prev_acc), 4);
    wait_done();

    repeat (3) @(negedge clk);
    check_output("scoreboard_drained", 32'(sb.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
